// File: rtl/ms6205_pkg.sv
// Shared types and constants for the MS6205 display controller.
package ms6205_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ADDR_STB, DATA_STB, WAIT_RDY} state_t;

  localparam int IP_DIGITS   = 5;
  localparam int LOOP_DIGITS = 3;
  localparam int AP_DIGITS   = 4;
  localparam int DATA_DIGITS = 3;
  localparam int DUMP_LEN    = IP_DIGITS + LOOP_DIGITS + AP_DIGITS + DATA_DIGITS;
  localparam int DUMP_BITS   = 4 * DUMP_LEN;

  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_A = 8'h41;
endpackage

// File: rtl/ms6205_if.sv
// Character bus between the controller (master) and the MS6205 display (slave).
interface ms6205_if;
  logic [7:0] address;
  logic [7:0] data;
  logic       write_addr;
  logic       write_data;
  logic       ready;

  modport master (output address, data, write_addr, write_data, input ready);
  modport slave  (input address, data, write_addr, write_data, output ready);
endinterface

// File: rtl/ms6205_hex2ascii.sv
// One hex nibble to its upper-case ASCII digit.
module hex2ascii
  import ms6205_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] code
);
  always_comb begin
    if (nib < 4'd10) code = ASCII_0 + {4'd0, nib};
    else             code = ASCII_A + {4'd0, nib} - 8'd10;
  end
endmodule

// File: rtl/ms6205_ctrl.sv
// Writes a hex dump of the CPU counters and keyboard echo characters to the
// MS6205 display, one character per LOAD/ADDR_STB/DATA_STB/WAIT_RDY sequence.
module ms6205_ctrl
  import ms6205_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [17:0] ipCounter,
  input  logic [8:0]  loopCounter,
  input  logic [14:0] apCounter,
  input  logic [8:0]  dataCounter,
  input  logic        refresh_req,
  input  logic        kb_req,
  input  logic [7:0]  kb_addr,
  input  logic [7:0]  kb_char,
  output logic        kb_ack,
  output logic        busy,
  ms6205_if.master    bus
);
  state_t               state, state_nx;
  logic                 pending, in_dump, cur_kb;
  logic                 more, char_done, enter_load, start_dump;
  logic [3:0]           idx, sel_idx, nib;
  logic [7:0]           addr_q, data_q, code;
  logic [DUMP_BITS-1:0] snap, live_vec, src_vec;

  assign live_vec = {(4*IP_DIGITS)'(ipCounter),  (4*LOOP_DIGITS)'(loopCounter),
                     (4*AP_DIGITS)'(apCounter),  (4*DATA_DIGITS)'(dataCounter)};

  // in_dump means chars of the current dump are still waiting to be loaded
  assign more       = kb_req | in_dump | pending;
  assign char_done  = (state == WAIT_RDY) && bus.ready;
  assign enter_load = ((state == IDLE) || char_done) && more;
  assign start_dump = !kb_req && !in_dump;

  // The first char of a dump reads the live counters, the snapshot lands at the same edge
  assign sel_idx = start_dump ? 4'd0 : idx;
  assign src_vec = start_dump ? live_vec : snap;

  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DUMP_LEN; i++)
      if (sel_idx == 4'(i)) nib = src_vec[4*(DUMP_LEN-1-i) +: 4];
  end

  hex2ascii u_hex2ascii (.nib(nib), .code(code));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (more) state_nx = LOAD;
      LOAD:     state_nx = ADDR_STB;
      ADDR_STB: state_nx = DATA_STB;
      DATA_STB: state_nx = WAIT_RDY;
      WAIT_RDY: if (bus.ready) state_nx = more ? LOAD : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      in_dump <= 1'b0;
      cur_kb  <= 1'b0;
      idx     <= 4'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      snap    <= '0;
    end else begin
      state <= state_nx;
      if (enter_load && start_dump) pending <= 1'b0;
      if (refresh_req)              pending <= 1'b1;
      if (enter_load) begin
        cur_kb <= kb_req;
        if (kb_req) begin
          addr_q <= kb_addr;
          data_q <= kb_char;
        end else begin
          addr_q  <= BASE_ADDR + {4'd0, sel_idx};
          data_q  <= code;
          idx     <= sel_idx + 4'd1;
          in_dump <= (sel_idx != 4'(DUMP_LEN-1));
          if (start_dump) snap <= live_vec;
        end
      end
    end
  end

  assign bus.address    = addr_q;
  assign bus.data       = data_q;
  assign bus.write_addr = (state == ADDR_STB);
  assign bus.write_data = (state == DATA_STB);
  assign kb_ack         = char_done && cur_kb;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_ms6205_ctrl.sv
// Directed + randomized bench for ms6205_ctrl; two instances (base 00 and F8) share inputs.
module tb_ms6205_ctrl;
  logic        clk = 1'b0;
  logic        Rst_n;
  logic [17:0] ip;
  logic [8:0]  lp, dt;
  logic [14:0] ap;
  logic        refresh_req, kb_req, ready;
  logic [7:0]  kb_addr, kb_char;
  logic        kb_ack_a, kb_ack_b, busy_a, busy_b;

  ms6205_if bus_a ();
  ms6205_if bus_b ();
  assign bus_a.ready = ready;
  assign bus_b.ready = ready;

  ms6205_ctrl dut_a (
    .Clk(clk), .Rst_n(Rst_n), .ipCounter(ip), .loopCounter(lp), .apCounter(ap),
    .dataCounter(dt), .refresh_req(refresh_req), .kb_req(kb_req), .kb_addr(kb_addr),
    .kb_char(kb_char), .kb_ack(kb_ack_a), .busy(busy_a), .bus(bus_a));

  ms6205_ctrl #(.BASE_ADDR(8'hF8)) dut_b (
    .Clk(clk), .Rst_n(Rst_n), .ipCounter(ip), .loopCounter(lp), .apCounter(ap),
    .dataCounter(dt), .refresh_req(refresh_req), .kb_req(kb_req), .kb_addr(kb_addr),
    .kb_char(kb_char), .kb_ack(kb_ack_b), .busy(busy_b), .bus(bus_b));

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_wd = 0, n_stb = 0, n_ack = 0, busy_cyc = 0;
  logic [15:0] wq_a[$], wq_b[$], exp_a[$], exp_b[$];

  // Observed writes, captured at the falling edge
  always @(negedge clk) begin
    if (bus_a.write_data) begin wq_a.push_back({bus_a.address, bus_a.data}); n_wd++; end
    if (bus_b.write_data) wq_b.push_back({bus_b.address, bus_b.data});
    if (bus_a.write_data || bus_a.write_addr) n_stb++;
    if (kb_ack_a) n_ack++;
    if (busy_a) busy_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: the dump is the four counters printed as zero-padded upper-case hex
  function automatic void push_dump(input logic [17:0] i_ip, input logic [8:0] i_lp,
                                    input logic [14:0] i_ap, input logic [8:0] i_dt,
                                    input int lo, input int hi);
    string s;
    logic [7:0] c, a;
    s = $sformatf("%h%h%h%h", i_ip, i_lp, i_ap, i_dt);
    for (int k = lo; k <= hi; k++) begin
      c = s[k];
      if (c >= "a") c = c - 8'h20;
      a = 8'(k);
      exp_a.push_back({a, c});
      a = 8'hF8 + 8'(k);
      exp_b.push_back({a, c});
    end
  endfunction

  function automatic void push_echo();
    exp_a.push_back({kb_addr, kb_char});
    exp_b.push_back({kb_addr, kb_char});
  endfunction

  task automatic cmp_q(input string tag);
    chk({tag, "_len_a"}, wq_a.size(), exp_a.size());
    chk({tag, "_len_b"}, wq_b.size(), exp_b.size());
    for (int i = 0; i < exp_a.size() && i < wq_a.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), wq_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < wq_b.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), wq_b[i], exp_b[i]);
    wq_a.delete(); wq_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_refresh();
    tick(); refresh_req = 1'b1;
    tick(); refresh_req = 1'b0;
  endtask

  task automatic rnd_cnt();
    ip = 18'($urandom); lp = 9'($urandom); ap = 15'($urandom); dt = 9'($urandom);
  endtask

  task automatic wait_idle(input bit rnd_ready, input string tag);
    int n = 0;
    do begin
      tick(); n++;
      if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
    end while ((n < 3 || busy_a) && n < 3000);
    ready = 1'b1;
    chk({tag, "_timeout"}, n < 3000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, bus_a.address, 0);
    chk({tag, "_data"}, bus_a.data, 0);
    chk({tag, "_wa"},   bus_a.write_addr, 0);
    chk({tag, "_wd"},   bus_a.write_data, 0);
    chk({tag, "_ack"},  kb_ack_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_addr_b"}, bus_b.address, 0);
  endtask

  initial begin
    int n;
    logic [7:0] s_addr, s_data;
    int s_stb, s_wd;
    bit stable;
    logic [17:0] v_ip; logic [8:0] v_lp, v_dt; logic [14:0] v_ap;

    Rst_n = 1'b1; ready = 1'b1; refresh_req = 1'b0; kb_req = 1'b0;
    kb_addr = 8'h00; kb_char = 8'h00; ip = '0; lp = '0; ap = '0; dt = '0;
    #2 Rst_n = 1'b0; #1;
    check_reset_outputs("rst");
    repeat (3) tick();
    Rst_n = 1'b1;
    tick();
    chk("idle_busy", busy_a, 0);

    // Fixed-value dump: exact characters, wrapped addresses on the F8 instance, 60 cycles
    ip = 18'h2A5F3; lp = 9'h1FF; ap = 15'h0001; dt = 9'h0A0;
    push_dump(ip, lp, ap, dt, 0, 14);
    busy_cyc = 0;
    pulse_refresh();
    wait_idle(0, "dump1");
    chk("dump1_cycles", busy_cyc, 60);
    chk("dump1_busy", busy_a, 0);
    chk("dump1_c0", exp_a[0][7:0], 8'h32);
    cmp_q("dump1");

    // Echo request during char 3: echo slots in, dump resumes at char 4
    rnd_cnt();
    kb_addr = 8'h40; kb_char = 8'h41;
    push_dump(ip, lp, ap, dt, 0, 3); push_echo(); push_dump(ip, lp, ap, dt, 4, 14);
    n_ack = 0;
    pulse_refresh();
    n = 0;
    while (bus_a.address != 8'h03 && n < 500) begin tick(); n++; end
    chk("kb_sync_timeout", n < 500, 1);
    kb_req = 1'b1;
    n = 0;
    while (!kb_ack_a && n < 500) begin tick(); n++; end
    chk("kb_ack_timeout", n < 500, 1);
    kb_req = 1'b0;
    wait_idle(0, "kbmid");
    chk("kbmid_acks", n_ack, 1);
    cmp_q("kbmid");

    // ready held low after char 0: frozen bus, no strobes, then the dump completes
    rnd_cnt();
    push_dump(ip, lp, ap, dt, 0, 14);
    pulse_refresh();
    n = 0;
    while (!bus_a.write_data && n < 500) begin tick(); n++; end
    chk("hold_sync_timeout", n < 500, 1);
    ready = 1'b0;
    s_addr = bus_a.address; s_data = bus_a.data; s_stb = n_stb; stable = 1'b1;
    repeat (20) begin
      tick();
      if (bus_a.address !== s_addr || bus_a.data !== s_data) stable = 1'b0;
    end
    chk("hold_strobes", n_stb - s_stb, 0);
    chk("hold_stable", stable, 1);
    chk("hold_addr", s_addr, 8'h00);
    chk("hold_data", s_data, exp_a[0][7:0]);
    chk("hold_busy", busy_a, 1);
    ready = 1'b1;
    wait_idle(0, "hold");
    cmp_q("hold");

    // Echo and refresh in the same cycle: echo first
    rnd_cnt();
    tick();
    kb_addr = 8'($urandom); kb_char = 8'($urandom);
    push_echo(); push_dump(ip, lp, ap, dt, 0, 14);
    kb_req = 1'b1; refresh_req = 1'b1;
    tick(); refresh_req = 1'b0;
    n = 0;
    while (!kb_ack_a && n < 500) begin tick(); n++; end
    chk("simul_ack_timeout", n < 500, 1);
    kb_req = 1'b0;
    wait_idle(0, "simul");
    cmp_q("simul");

    // Counter change mid-dump is invisible; refresh mid-dump gives exactly one more dump
    rnd_cnt();
    v_ip = ip; v_lp = lp; v_ap = ap; v_dt = dt;
    push_dump(v_ip, v_lp, v_ap, v_dt, 0, 14);
    push_dump(18'h0, v_lp, v_ap, v_dt, 0, 14);
    pulse_refresh();
    n = 0;
    while (bus_a.address != 8'h05 && n < 500) begin tick(); n++; end
    chk("snap_sync_timeout", n < 500, 1);
    ip = 18'h0;
    pulse_refresh();
    wait_idle(0, "snap");
    cmp_q("snap");

    // Random counters with random display back-pressure
    for (int r = 0; r < 5; r++) begin
      rnd_cnt();
      push_dump(ip, lp, ap, dt, 0, 14);
      pulse_refresh();
      wait_idle(1, $sformatf("rnd%0d", r));
      cmp_q($sformatf("rnd%0d", r));
    end

    // Reset during ADDR_STB of char 7: outputs clear at once, dump abandoned
    rnd_cnt();
    push_dump(ip, lp, ap, dt, 0, 6);
    pulse_refresh();
    n = 0;
    while (!(bus_a.write_addr && bus_a.address == 8'h07) && n < 500) begin tick(); n++; end
    chk("rstmid_sync_timeout", n < 500, 1);
    Rst_n = 1'b0;
    #1;
    check_reset_outputs("rstmid");
    s_wd = n_wd;
    repeat (3) tick();
    Rst_n = 1'b1;
    repeat (20) tick();
    chk("rstmid_no_wd", n_wd - s_wd, 0);
    chk("rstmid_idle", busy_a, 0);
    cmp_q("rstmid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
